l1icache_line: RTL and testbench



---
 rtl/l1icache_line_if.sv | 35 +++
 rtl/l1icache_line.sv | 205 ++++++++++++++++++++
 tb/tb_l1icache_line.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/l1icache_line_if.sv
// Fetch-side request/response handshake and Wishbone refill bus of the L1 instruction cache.
// Signal suffixes are named from the cache's point of view.
interface l1icache_line_if #(
    parameter int unsigned ADDR_LEN    = 32,
    parameter int unsigned WB_DATA_LEN = 32
);
    logic                   req_valid_i;
    logic                   req_ready_o;
    logic [ADDR_LEN-1:0]    req_addr_i;
    logic                   flush_i;
    logic                   resp_valid_o;
    logic                   resp_ready_i;
    logic [WB_DATA_LEN-1:0] resp_data_o;
    logic [ADDR_LEN-1:0]    resp_addr_o;
    logic                   wb_cyc_o;
    logic                   wb_stb_o;
    logic                   wb_we_o;
    logic                   wb_bry_o;
    logic [ADDR_LEN-1:0]    wb_adr_o;
    logic [9:0]             wb_bl_o;
    logic                   wb_ack_i;
    logic [WB_DATA_LEN-1:0] wb_dat_i;

    modport slave (
        input  req_valid_i, req_addr_i, flush_i, resp_ready_i, wb_ack_i, wb_dat_i,
        output req_ready_o, resp_valid_o, resp_data_o, resp_addr_o,
               wb_cyc_o, wb_stb_o, wb_we_o, wb_bry_o, wb_adr_o, wb_bl_o
    );

    modport master (
        output req_valid_i, req_addr_i, flush_i, resp_ready_i, wb_ack_i, wb_dat_i,
        input  req_ready_o, resp_valid_o, resp_data_o, resp_addr_o,
               wb_cyc_o, wb_stb_o, wb_we_o, wb_bry_o, wb_adr_o, wb_bl_o
    );
endinterface

// File: rtl/l1icache_line.sv
// Direct-mapped blocking L1 instruction cache with multi-word lines, critical-word return,
// flush and hit/miss counters; refills over a Wishbone burst into external tag/data SRAMs.
module l1icache_line #(
    parameter  int unsigned ADDR_LEN    = 32,
    parameter  int unsigned WB_DATA_LEN = 32,
    parameter  int unsigned INDEX_BITS  = 6,
    parameter  int unsigned LINE_WORDS  = 4,
    localparam int unsigned OFF         = $clog2(LINE_WORDS),
    localparam int unsigned TAG_W       = ADDR_LEN - INDEX_BITS - OFF - 2,
    localparam int unsigned DAW         = INDEX_BITS + OFF
) (
    input  logic                   clk,
    input  logic                   rstn,
    l1icache_line_if.slave         bus,
    output logic                   tag_csb_o,
    output logic                   tag_web_o,
    output logic [INDEX_BITS-1:0]  tag_addr_o,
    output logic [TAG_W:0]         tag_din_o,
    input  logic [TAG_W:0]         tag_dout_i,
    output logic                   data_csb_o,
    output logic                   data_web_o,
    output logic [DAW-1:0]         data_addr_o,
    output logic [WB_DATA_LEN-1:0] data_din_o,
    input  logic [WB_DATA_LEN-1:0] data_dout_i,
    output logic [31:0]            hit_cnt_o,
    output logic [31:0]            miss_cnt_o
);
    localparam int unsigned BW = (OFF > 0) ? OFF : 1;
    localparam int unsigned WA = ADDR_LEN - 2;

    typedef enum logic [2:0] {INIT, IDLE, LOOKUP, REFILL, RESP} state_e;

    state_e                 state_q, state_d;
    logic [INDEX_BITS-1:0]  icnt_q, icnt_d;
    logic                   flush_pend_q, flush_pend_d;
    logic [WA-1:0]          addr_q, addr_d;
    logic [BW-1:0]          beat_q, beat_d;
    logic [WB_DATA_LEN-1:0] resp_data_q, resp_data_d;
    logic [ADDR_LEN-1:0]    resp_addr_q, resp_addr_d;
    logic                   resp_valid_q, resp_valid_d;
    logic                   wb_cyc_q, wb_cyc_d;
    logic [ADDR_LEN-1:0]    wb_adr_q, wb_adr_d;
    logic [31:0]            hit_cnt_q, hit_cnt_d;
    logic [31:0]            miss_cnt_q, miss_cnt_d;

    // Address fields of the latched (word) address and of the incoming request
    logic [TAG_W-1:0]      tag_q;
    logic [INDEX_BITS-1:0] idx_q, req_idx;
    logic [BW-1:0]         word_q, req_word;
    logic [ADDR_LEN-1:0]   line_adr_q;
    logic                  hit_c, req_ready_c;

    assign tag_q      = TAG_W'(addr_q >> (INDEX_BITS + OFF));
    assign idx_q      = INDEX_BITS'(addr_q >> OFF);
    assign word_q     = BW'(addr_q) & BW'(LINE_WORDS - 1);
    assign req_idx    = INDEX_BITS'(bus.req_addr_i >> (OFF + 2));
    assign req_word   = BW'(bus.req_addr_i >> 2) & BW'(LINE_WORDS - 1);
    assign line_adr_q = ADDR_LEN'(addr_q >> OFF) << (OFF + 2);
    assign hit_c      = tag_dout_i[TAG_W] && (tag_dout_i[TAG_W-1:0] == tag_q);
    assign req_ready_c = (state_q == IDLE) && !bus.flush_i && !flush_pend_q;

    assign bus.req_ready_o  = req_ready_c;
    assign bus.resp_valid_o = resp_valid_q;
    assign bus.resp_data_o  = resp_data_q;
    assign bus.resp_addr_o  = resp_addr_q;
    assign bus.wb_cyc_o     = wb_cyc_q;
    assign bus.wb_stb_o     = wb_cyc_q;
    assign bus.wb_bry_o     = wb_cyc_q;
    assign bus.wb_we_o      = 1'b0;
    assign bus.wb_adr_o     = wb_adr_q;
    assign bus.wb_bl_o      = wb_cyc_q ? 10'(LINE_WORDS) : 10'd0;
    assign hit_cnt_o        = hit_cnt_q;
    assign miss_cnt_o       = miss_cnt_q;

    // Next-state, SRAM strobes and registered-output inputs
    always_comb begin
        state_d      = state_q;
        icnt_d       = icnt_q;
        flush_pend_d = flush_pend_q;
        addr_d       = addr_q;
        beat_d       = beat_q;
        resp_data_d  = resp_data_q;
        resp_addr_d  = resp_addr_q;
        hit_cnt_d    = hit_cnt_q;
        miss_cnt_d   = miss_cnt_q;
        tag_csb_o    = 1'b1;
        tag_web_o    = 1'b1;
        tag_addr_o   = idx_q;
        tag_din_o    = '0;
        data_csb_o   = 1'b1;
        data_web_o   = 1'b1;
        data_addr_o  = (DAW'(idx_q) << OFF) | DAW'(beat_q);
        data_din_o   = bus.wb_dat_i;

        // INIT is already clearing every tag, so a flush there needs no record
        if (bus.flush_i && (state_q != IDLE) && (state_q != INIT)) flush_pend_d = 1'b1;

        case (state_q)
            INIT: begin
                tag_csb_o  = 1'b0;
                tag_web_o  = 1'b0;
                tag_addr_o = icnt_q;
                icnt_d     = icnt_q + INDEX_BITS'(1);
                if (&icnt_q) state_d = IDLE;
            end
            IDLE: begin
                if (bus.flush_i || flush_pend_q) begin
                    flush_pend_d = 1'b0;
                    icnt_d       = '0;
                    state_d      = INIT;
                end else if (bus.req_valid_i) begin
                    addr_d      = bus.req_addr_i[ADDR_LEN-1:2];
                    tag_csb_o   = 1'b0;
                    tag_addr_o  = req_idx;
                    data_csb_o  = 1'b0;
                    data_addr_o = (DAW'(req_idx) << OFF) | DAW'(req_word);
                    state_d     = LOOKUP;
                end
            end
            LOOKUP: begin
                if (hit_c) begin
                    resp_data_d = data_dout_i;
                    resp_addr_d = {addr_q, 2'b00};
                    hit_cnt_d   = hit_cnt_q + 32'd1;
                    state_d     = RESP;
                end else begin
                    miss_cnt_d = miss_cnt_q + 32'd1;
                    beat_d     = '0;
                    state_d    = REFILL;
                end
            end
            REFILL: begin
                if (bus.wb_ack_i) begin
                    data_csb_o = 1'b0;
                    data_web_o = 1'b0;
                    beat_d     = beat_q + BW'(1);
                    if (beat_q == word_q) begin
                        resp_data_d = bus.wb_dat_i;
                        resp_addr_d = {addr_q, 2'b00};
                    end
                    // Tag goes valid only with the final beat, so a cut-short line stays invalid
                    if (beat_q == BW'(LINE_WORDS - 1)) begin
                        tag_csb_o = 1'b0;
                        tag_web_o = 1'b0;
                        tag_din_o = {1'b1, tag_q};
                        state_d   = RESP;
                    end
                end
            end
            RESP: begin
                if (bus.resp_ready_i) begin
                    if (flush_pend_d) begin
                        flush_pend_d = 1'b0;
                        icnt_d       = '0;
                        state_d      = INIT;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = INIT;
        endcase

        resp_valid_d = (state_d == RESP);
        wb_cyc_d     = (state_d == REFILL);
        wb_adr_d     = (state_d == REFILL) ? line_adr_q : '0;

        if (!rstn) begin
            tag_csb_o  = 1'b1;
            tag_web_o  = 1'b1;
            data_csb_o = 1'b1;
            data_web_o = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q      <= INIT;
            icnt_q       <= '0;
            flush_pend_q <= 1'b0;
            addr_q       <= '0;
            beat_q       <= '0;
            resp_data_q  <= '0;
            resp_addr_q  <= '0;
            resp_valid_q <= 1'b0;
            wb_cyc_q     <= 1'b0;
            wb_adr_q     <= '0;
            hit_cnt_q    <= '0;
            miss_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            icnt_q       <= icnt_d;
            flush_pend_q <= flush_pend_d;
            addr_q       <= addr_d;
            beat_q       <= beat_d;
            resp_data_q  <= resp_data_d;
            resp_addr_q  <= resp_addr_d;
            resp_valid_q <= resp_valid_d;
            wb_cyc_q     <= wb_cyc_d;
            wb_adr_q     <= wb_adr_d;
            hit_cnt_q    <= hit_cnt_d;
            miss_cnt_q   <= miss_cnt_d;
        end
    end
endmodule

// File: tb/tb_l1icache_line.sv
// Randomized bench for l1icache_line: SRAM and Wishbone models around the DUT, checked
// against a set/tag presence model and a fixed backing-memory function.
module tb_l1icache_line;
    localparam int unsigned AL    = 32;
    localparam int unsigned DL    = 32;
    localparam int unsigned IB    = 6;
    localparam int unsigned LW    = 4;
    localparam int unsigned OFF   = 2;
    localparam int unsigned TW    = AL - IB - OFF - 2;
    localparam int unsigned NSETS = 1 << IB;
    localparam int unsigned LINE_BYTES = 4 * LW;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    l1icache_line_if #(.ADDR_LEN(AL), .WB_DATA_LEN(DL)) bus();

    logic              tag_csb, tag_web, data_csb, data_web;
    logic [IB-1:0]     tag_addr;
    logic [TW:0]       tag_din, tag_dout;
    logic [IB+OFF-1:0] data_addr;
    logic [DL-1:0]     data_din, data_dout;
    logic [31:0]       hit_cnt, miss_cnt;

    l1icache_line #(.ADDR_LEN(AL), .WB_DATA_LEN(DL), .INDEX_BITS(IB), .LINE_WORDS(LW)) dut (
        .clk(clk), .rstn(rstn), .bus(bus),
        .tag_csb_o(tag_csb), .tag_web_o(tag_web), .tag_addr_o(tag_addr),
        .tag_din_o(tag_din), .tag_dout_i(tag_dout),
        .data_csb_o(data_csb), .data_web_o(data_web), .data_addr_o(data_addr),
        .data_din_o(data_din), .data_dout_i(data_dout),
        .hit_cnt_o(hit_cnt), .miss_cnt_o(miss_cnt)
    );

    // Single-port SRAMs, one-cycle read latency
    logic [TW:0]   tag_mem  [NSETS];
    logic [DL-1:0] data_mem [NSETS*LW];
    always @(posedge clk) begin
        if (!tag_csb) begin
            if (!tag_web) tag_mem[tag_addr] <= tag_din;
            else          tag_dout <= tag_mem[tag_addr];
        end
        if (!data_csb) begin
            if (!data_web) data_mem[data_addr] <= data_din;
            else           data_dout <= data_mem[data_addr];
        end
    end

    int cyc_cnt = 0;
    always @(posedge clk) cyc_cnt++;

    int n_checks = 0;
    int n_fail   = 0;
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc_cnt);
        end
    endtask

    // Backing memory: the 0x1230 line holds 0xA0..0xA3, everything else a hash of the address
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] w;
        w = a & 32'hFFFF_FFFC;
        if ((w >> 4) == 32'h123) return 32'hA0 + ((w >> 2) & 32'h3);
        return (w * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    // Wishbone slave: ascending beats from offset 0, random ack gaps
    int bus_beat = 0;
    int last_ack_cyc = 0;
    int ack_pct = 100;
    always @(negedge clk) begin
        if (bus.wb_cyc_o === 1'b1 && bus_beat < LW && $urandom_range(0, 99) < ack_pct) begin
            bus.wb_ack_i = 1'b1;
            bus.wb_dat_i = mem_word(bus.wb_adr_o + 32'(4 * bus_beat));
            bus_beat++;
            if (bus_beat == LW) last_ack_cyc = cyc_cnt;
        end else begin
            bus.wb_ack_i = 1'b0;
            bus.wb_dat_i = $urandom;
        end
        if (bus.wb_cyc_o !== 1'b1) bus_beat = 0;
    end

    // Reference model: which tag each set holds, and expected counters
    bit          ref_valid [NSETS];
    logic [31:0] ref_tag   [NSETS];
    logic [31:0] exp_hit = 0;
    logic [31:0] exp_miss = 0;

    function automatic void model_clear();
        for (int i = 0; i < NSETS; i++) ref_valid[i] = 1'b0;
    endfunction

    // Count INIT tag writes until the cache accepts requests again
    task automatic check_init(input string tag);
        int n = 0, cnt = 0;
        bit bad = 1'b0;
        while (bus.req_ready_o !== 1'b1 && n < 300) begin
            if (tag_csb === 1'b0 && tag_web === 1'b0) begin
                if (tag_addr !== IB'(cnt) || tag_din !== '0) bad = 1'b1;
                cnt++;
            end
            @(negedge clk);
            n++;
        end
        check({tag, "_len"}, 64'(cnt), 64'(NSETS));
        check({tag, "_seq"}, 64'(bad), 64'd0);
    endtask

    task automatic do_req(input logic [31:0] a, input int hold, input bit flush_mid);
        int idx, n, hs_cyc;
        logic [31:0] tg, exp_d;
        bit exp_hit_b, seen_cyc, flushed;
        idx = int'((a / LINE_BYTES) % NSETS);
        tg  = a / (LINE_BYTES * NSETS);
        exp_d = mem_word(a);
        n = 0;
        while (bus.req_ready_o !== 1'b1 && n < 300) begin @(negedge clk); n++; end
        if (bus.req_ready_o !== 1'b1) begin check("req_ready_timeout", 0, 1); return; end
        bus.req_valid_i = 1'b1;
        bus.req_addr_i  = a;
        hs_cyc = cyc_cnt;
        @(negedge clk);
        bus.req_valid_i = 1'b0;
        bus.req_addr_i  = $urandom;

        exp_hit_b = ref_valid[idx] && (ref_tag[idx] == tg);
        if (exp_hit_b) exp_hit++;
        else begin exp_miss++; ref_valid[idx] = 1'b1; ref_tag[idx] = tg; end

        seen_cyc = 1'b0; flushed = 1'b0; n = 0;
        while (bus.resp_valid_o !== 1'b1 && n < 600) begin
            if (bus.wb_cyc_o === 1'b1 && !seen_cyc) begin
                seen_cyc = 1'b1;
                check("wb_adr", bus.wb_adr_o, a & ~(LINE_BYTES - 1));
                check("wb_bl", bus.wb_bl_o, LW);
            end
            if (flush_mid && seen_cyc && !flushed) begin bus.flush_i = 1'b1; flushed = 1'b1; end
            else bus.flush_i = 1'b0;
            @(negedge clk);
            n++;
        end
        bus.flush_i = 1'b0;
        if (bus.resp_valid_o !== 1'b1) begin check("resp_timeout", 0, 1); return; end

        check("bus_used_iff_miss", 64'(seen_cyc), 64'(!exp_hit_b));
        if (exp_hit_b) check("hit_latency", 64'(cyc_cnt - hs_cyc), 64'd2);
        else           check("miss_latency", 64'(cyc_cnt - last_ack_cyc), 64'd1);

        for (int i = 0; i < hold; i++) begin
            check("bp_valid", bus.resp_valid_o, 1);
            check("bp_data", bus.resp_data_o, exp_d);
            check("bp_req_ready", bus.req_ready_o, 0);
            check("bp_counters", {hit_cnt, miss_cnt}, {exp_hit, exp_miss});
            @(negedge clk);
        end
        check("resp_data", bus.resp_data_o, exp_d);
        check("resp_addr", bus.resp_addr_o, a & 32'hFFFF_FFFC);
        check("hit_cnt", hit_cnt, exp_hit);
        check("miss_cnt", miss_cnt, exp_miss);
        bus.resp_ready_i = 1'b1;
        @(negedge clk);
        bus.resp_ready_i = 1'b0;
        check("resp_valid_drop", bus.resp_valid_o, 0);
        if (flush_mid) begin
            model_clear();
            check_init("flush_mid_init");
        end
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] idx_pool [4];
        idx_pool[0] = 32'h23; idx_pool[1] = 32'h00; idx_pool[2] = 32'h3F; idx_pool[3] = 32'h05;
        return (32'($urandom_range(3, 6)) << 10) | (idx_pool[$urandom_range(0, 3)] << 4)
             | (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3));
    endfunction

    initial begin
        int n;
        bus.req_valid_i  = 1'b0;
        bus.req_addr_i   = '0;
        bus.flush_i      = 1'b0;
        bus.resp_ready_i = 1'b0;
        for (int i = 0; i < NSETS; i++) tag_mem[i] = '0;
        for (int i = 0; i < NSETS * LW; i++) data_mem[i] = '0;
        model_clear();

        // Reset for two cycles
        repeat (2) @(negedge clk);
        check("rst_resp_valid", bus.resp_valid_o, 0);
        check("rst_req_ready", bus.req_ready_o, 0);
        check("rst_wb_cyc", bus.wb_cyc_o, 0);
        check("rst_sram_idle", {tag_csb, tag_web, data_csb, data_web}, 4'hF);
        check("rst_counters", {hit_cnt, miss_cnt}, 64'd0);
        check("rst_resp_data", bus.resp_data_o, 0);
        rstn = 1'b1;
        #1;
        check_init("reset_init");

        // Directed: cold miss with critical word, hit, conflict eviction, backpressure
        ack_pct = 100;
        do_req(32'h0000_1238, 0, 1'b0);
        do_req(32'h0000_1234, 0, 1'b0);
        do_req(32'h0000_2230, 0, 1'b0);
        do_req(32'h0000_1230, 0, 1'b0);
        do_req(32'h0000_1234, 5, 1'b0);

        // Flush mid-burst, then the flushed line misses again
        ack_pct = 50;
        do_req(32'h0000_2234, 1, 1'b1);
        do_req(32'h0000_1234, 0, 1'b0);

        // Random traffic with occasional idle flushes
        for (int t = 0; t < 150; t++) begin
            ack_pct = $urandom_range(30, 100);
            if ($urandom_range(0, 15) == 0) begin
                n = 0;
                while (bus.req_ready_o !== 1'b1 && n < 300) begin @(negedge clk); n++; end
                bus.flush_i = 1'b1;
                #1;
                check("idle_flush_ready", bus.req_ready_o, 0);
                @(negedge clk);
                bus.flush_i = 1'b0;
                model_clear();
                check_init("idle_flush_init");
            end
            do_req(rand_addr(), $urandom_range(0, 3), 1'b0);
        end

        // Reset in the middle of a refill
        ack_pct = 30;
        n = 0;
        while (bus.req_ready_o !== 1'b1 && n < 300) begin @(negedge clk); n++; end
        bus.req_valid_i = 1'b1;
        bus.req_addr_i  = 32'h0000_1630;
        @(negedge clk);
        bus.req_valid_i = 1'b0;
        n = 0;
        while (bus.wb_cyc_o !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        check("mid_rst_refill_started", bus.wb_cyc_o, 1);
        @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        check("mid_rst_wb_cyc", bus.wb_cyc_o, 0);
        check("mid_rst_resp_valid", bus.resp_valid_o, 0);
        check("mid_rst_counters", {hit_cnt, miss_cnt}, 64'd0);
        rstn = 1'b1;
        #1;
        model_clear();
        exp_hit = 0;
        exp_miss = 0;
        check_init("mid_rst_init");
        do_req(32'h0000_1630, 0, 1'b0);
        do_req(32'h0000_1634, 0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
